result_uart_tx: RTL and testbench

- Downstream consumer of the 8-bit cell-result bus driven by the cell-mux / ring-oscillator stage.
- The result bus changes on the slow switch clock, so it is asynchronous to clk.
- This block synchronises and debounces the bus, then serialises snapshots as UART 8N1 frames (LSB first) on a single pin.
- A frame is sent on an explicit request, or automatically whenever the stable value changes.

---
 rtl/result_uart_tx_pkg.sv | 20 ++
 rtl/result_uart_tx_if.sv | 30 +++
 rtl/result_uart_tx_input_stabilizer.sv | 62 ++++++
 rtl/result_uart_tx.sv | 147 ++++++++++++++
 tb/tb_result_uart_tx.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/result_uart_tx_pkg.sv
// Shared types and constants for the result UART transmitter.
// Imported by the stabiliser, the interface users and the top.
package result_uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  // Width of a counter that must reach n-1; never narrower than 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_uart_tx_if.sv
// Result-bus and UART line bundle between the cell-mux stage
// and the transmitter.
interface result_uart_tx_if;

  logic [7:0] data_in;
  logic       send_on_change;
  logic       send_req;
  logic       tx;
  logic       busy;
  logic       overrun;

  modport master (
    output data_in,
    output send_on_change,
    output send_req,
    input  tx,
    input  busy,
    input  overrun
  );

  modport slave (
    input  data_in,
    input  send_on_change,
    input  send_req,
    output tx,
    output busy,
    output overrun
  );

endinterface

// File: rtl/result_uart_tx_input_stabilizer.sv
// Two-flop synchroniser plus debounce for the slow result bus.
// A value is accepted after STABLE_CYCLES identical samples.
module input_stabilizer
  import result_uart_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  output logic [7:0] stable_o,
  output logic       updated_o
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [7:0]    sync1_q;
  logic [7:0]    sync2_q;
  logic [7:0]    prev_q;
  logic [7:0]    stable_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          upd_q;
  logic          load;

  // Count consecutive equal samples; load when the run is long enough.
  always_comb begin
    cnt_d = cnt_q;
    load  = 1'b0;
    if (sync2_q != prev_q) begin
      cnt_d = '0;
      load  = (STABLE_CYCLES == 1);
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
      load  = ((cnt_q + CW'(1)) == LAST);
    end
  end

  // Synchroniser, sample history, counter and accepted value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      upd_q    <= 1'b0;
    end else begin
      sync1_q <= data_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      upd_q   <= load;
      if (load) stable_q <= sync2_q;
    end
  end

  assign stable_o  = stable_q;
  assign updated_o = upd_q;

endmodule

// File: rtl/result_uart_tx.sv
// Serialises debounced result-bus snapshots as UART 8N1 frames.
// Frames go out on request or when the stable value changes.
module result_uart_tx
  import result_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 104,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  result_uart_tx_if.slave  bus
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int IW = cnt_width(UART_DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    last_q, last_d;
  logic          pend_q, pend_d;
  logic          ovr_q, ovr_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic [7:0]    stable;
  logic          unused_upd;
  logic          trig;
  logic          bit_end;

  input_stabilizer #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stab (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_i    (bus.data_in),
    .stable_o  (stable),
    .updated_o (unused_upd)
  );

  assign trig = bus.send_req |
                (bus.send_on_change & (stable != last_q));
  assign bit_end = (cnt_q == BIT_LAST);

  // Next-state, line level and request bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    last_d  = last_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (trig || pend_q) begin
          shift_d = stable;
          last_d  = stable;
          pend_d  = 1'b0;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            idx_d = idx_q + IW'(1);
            tx_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // One request may wait behind a frame; a second one is lost.
    if (bus.send_req && (state_q != IDLE)) begin
      if (pend_q) ovr_d = 1'b1;
      else        pend_d = 1'b1;
    end
  end

  // State and datapath registers; line forced idle by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      last_q  <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx.
// Frames are decoded off the line and compared with a byte model.
module tb_result_uart_tx;

  localparam int CPB = 4;
  localparam int STC = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  result_uart_tx_if ifc ();

  result_uart_tx #(
    .CLKS_PER_BIT  (CPB),
    .STABLE_CYCLES (STC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  logic [9:0] rx_q[$];
  int         rxs_q[$];
  int         brun_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_last;
  int         brun = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Line receiver: start seen at first low cycle, then mid-bit samples.
  always begin : mon
    logic [9:0] fb;
    int st;
    @(negedge clk);
    if (mon_en && ifc.tx === 1'b0) begin
      st = cyc;
      fb = '0;
      repeat (CPB / 2) @(negedge clk);
      fb[0] = ifc.tx;
      for (int k = 1; k < 10; k++) begin
        repeat (CPB) @(negedge clk);
        fb[k] = ifc.tx;
      end
      if (mon_en) begin
        rx_q.push_back(fb);
        rxs_q.push_back(st);
      end
    end
  end

  // Length of every busy pulse.
  always @(negedge clk) begin
    if (ifc.busy === 1'b1) brun <= brun + 1;
    else begin
      if (brun != 0 && mon_en) brun_q.push_back(brun);
      brun <= 0;
    end
  end

  task automatic clear_q();
    rx_q.delete();
    rxs_q.delete();
    brun_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    @(posedge clk);
    #1 ifc.send_req = 1'b1;
    @(posedge clk);
    #1 ifc.send_req = 1'b0;
  endtask

  task automatic set_data(input logic [7:0] v);
    @(posedge clk);
    #1 ifc.data_in = v;
  endtask

  task automatic wait_idle(output bit ok);
    int low;
    low = 0;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      if (ifc.busy === 1'b0) low++;
      else low = 0;
      if (low >= 12) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    ifc.data_in = 8'h00;
    ifc.send_on_change = 1'b0;
    ifc.send_req = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    total++;
    if ({ifc.tx, ifc.busy, ifc.overrun} !== 3'b100) begin
      bad++;
      $display("FAIL rst_state: got tx/busy/ovr=%b want 100",
               {ifc.tx, ifc.busy, ifc.overrun});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({ifc.tx, ifc.busy, ifc.overrun} !== 3'b100) begin
        bad++;
        $display("FAIL idle_%0d: got tx/busy/ovr=%b want 100",
                 i, {ifc.tx, ifc.busy, ifc.overrun});
      end
    end
    m_last = 8'h00;
  endtask

  task automatic test_a5();
    bit ok;
    clear_q();
    set_data(8'hA5);
    wait_cycles(10);
    pulse_req();
    total++;
    if ({ifc.tx, ifc.busy} !== 2'b01) begin
      bad++;
      $display("FAIL a5_latency: got tx/busy=%b want 01",
               {ifc.tx, ifc.busy});
    end
    exp_q.push_back(8'hA5);
    m_last = 8'hA5;
    wait_idle(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL a5_idle: got timeout want idle");
    end
    total++;
    if (rx_q.size() != 1 || brun_q.size() != 1) begin
      bad++;
      $display("FAIL a5_count: got frames=%0d busy=%0d want 1 1",
               rx_q.size(), brun_q.size());
    end else begin
      total++;
      if (rx_q[0] !== 10'b1_1010_0101_0) begin
        bad++;
        $display("FAIL a5_bits: got %b want %b",
                 rx_q[0], 10'b1_1010_0101_0);
      end
      total++;
      if (brun_q[0] != 10 * CPB) begin
        bad++;
        $display("FAIL a5_busy: got %0d want %0d", brun_q[0], 10 * CPB);
      end
    end
  endtask

  task automatic test_auto_change();
    bit ok;
    int c;
    set_data(8'h00);
    wait_cycles(10);
    ifc.send_on_change = 1'b1;
    wait_idle(ok);
    m_last = 8'h00;
    clear_q();
    set_data(8'h3C);
    c = cyc;
    exp_q.push_back(8'h3C);
    m_last = 8'h3C;
    wait_idle(ok);
    wait_cycles(60);
    total++;
    if (rx_q.size() != 1) begin
      bad++;
      $display("FAIL auto_count: got %0d want 1", rx_q.size());
    end else begin
      total++;
      if (rx_q[0] !== {1'b1, exp_q[0], 1'b0}) begin
        bad++;
        $display("FAIL auto_data: got %b want %b",
                 rx_q[0], {1'b1, exp_q[0], 1'b0});
      end
      total++;
      if (rxs_q[0] != c + 6) begin
        bad++;
        $display("FAIL auto_start: got +%0d want +6", rxs_q[0] - c);
      end
    end
  endtask

  task automatic test_glitch();
    bit ok;
    set_data(8'h00);
    wait_idle(ok);
    m_last = 8'h00;
    clear_q();
    set_data(8'hFF);
    wait_cycles(2);
    ifc.data_in = 8'h00;
    wait_cycles(40);
    total++;
    if (rx_q.size() != 0 || brun_q.size() != 0) begin
      bad++;
      $display("FAIL glitch_quiet: got frames=%0d want 0", rx_q.size());
    end
    pulse_req();
    wait_idle(ok);
    total++;
    if (rx_q.size() != 1 || rx_q[0] !== 10'b1_0000_0000_0) begin
      bad++;
      $display("FAIL glitch_stable: got n=%0d f=%b want 1 %b",
               rx_q.size(), rx_q.size() ? rx_q[0] : 10'h0,
               10'b1_0000_0000_0);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    ifc.send_on_change = 1'b0;
    clear_q();
    set_data(8'h11);
    wait_cycles(10);
    total++;
    if (ifc.overrun !== 1'b0) begin
      bad++;
      $display("FAIL ovr_pre: got %b want 0", ifc.overrun);
    end
    pulse_req();
    wait_cycles(5);
    pulse_req();
    wait_cycles(3);
    pulse_req();
    total++;
    if (ifc.overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_set: got %b want 1", ifc.overrun);
    end
    wait_idle(ok);
    m_last = 8'h11;
    total++;
    if (rx_q.size() != 2 || brun_q.size() != 2) begin
      bad++;
      $display("FAIL ovr_count: got frames=%0d busy=%0d want 2 2",
               rx_q.size(), brun_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (rx_q[i] !== 10'b1_0001_0001_0 || brun_q[i] != 10 * CPB) begin
          bad++;
          $display("FAIL ovr_frame%0d: got %b/%0d want %b/%0d", i,
                   rx_q[i], brun_q[i], 10'b1_0001_0001_0, 10 * CPB);
        end
      end
      total++;
      if (rxs_q[1] - rxs_q[0] < 10 * CPB + 1) begin
        bad++;
        $display("FAIL ovr_gap: got %0d want >=%0d",
                 rxs_q[1] - rxs_q[0], 10 * CPB + 1);
      end
    end
    total++;
    if (ifc.overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_sticky: got %b want 1", ifc.overrun);
    end
  endtask

  task automatic test_frozen();
    bit ok;
    clear_q();
    ifc.send_on_change = 1'b1;
    set_data(8'h01);
    wait_cycles(16);
    ifc.data_in = 8'h02;
    wait_cycles(8);
    ifc.data_in = 8'h03;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h03);
    m_last = 8'h03;
    wait_idle(ok);
    total++;
    if (rx_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL frozen_count: got %0d want %0d",
               rx_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        total++;
        if (rx_q[i] !== {1'b1, exp_q[i], 1'b0}) begin
          bad++;
          $display("FAIL frozen_f%0d: got %b want %b", i,
                   rx_q[i], {1'b1, exp_q[i], 1'b0});
        end
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] v;
    clear_q();
    ifc.send_on_change = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v = ($urandom_range(0, 3) == 0) ? m_last
                                     : 8'($urandom_range(0, 255));
      set_data(v);
      wait_cycles(60);
      if (v != m_last) begin
        exp_q.push_back(v);
        m_last = v;
      end
    end
    ifc.send_on_change = 1'b0;
    for (int i = 0; i < 6; i++) begin
      v = 8'($urandom_range(0, 255));
      set_data(v);
      wait_cycles(8);
      pulse_req();
      exp_q.push_back(v);
      m_last = v;
      wait_cycles(50);
    end
    wait_idle(ok);
    total++;
    if (rx_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL rand_count: got %0d want %0d",
               rx_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        total++;
        if (rx_q[i] !== {1'b1, exp_q[i], 1'b0}) begin
          bad++;
          $display("FAIL rand_f%0d: got %b want %b", i,
                   rx_q[i], {1'b1, exp_q[i], 1'b0});
        end
      end
    end
  endtask

  task automatic test_midframe_reset();
    ifc.send_on_change = 1'b0;
    set_data(8'h5A);
    wait_cycles(10);
    pulse_req();
    wait_cycles(12);
    mon_en = 1'b0;
    total++;
    if ({ifc.tx, ifc.busy} !== 2'b01) begin
      bad++;
      $display("FAIL mid_pre: got tx/busy=%b want 01",
               {ifc.tx, ifc.busy});
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ifc.tx, ifc.busy, ifc.overrun} !== 3'b100) begin
      bad++;
      $display("FAIL mid_async: got tx/busy/ovr=%b want 100",
               {ifc.tx, ifc.busy, ifc.overrun});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cycles(20);
    total++;
    if ({ifc.tx, ifc.busy, ifc.overrun} !== 3'b100) begin
      bad++;
      $display("FAIL mid_after: got tx/busy/ovr=%b want 100",
               {ifc.tx, ifc.busy, ifc.overrun});
    end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_auto_change();
    test_glitch();
    test_overrun();
    test_frozen();
    test_random();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
